// File: rtl/thermal_pkg.sv
// ----------------------------------------------------------------------------
// thermal_pkg
// Shared types and helpers for the thermal shutdown controller.
//   thermal_state_t : per-channel protection state.
//   cnt_width()     : width of the per-channel debounce/cool-down counter,
//                     wide enough to hold max(deb, cool) without wrapping.
// ----------------------------------------------------------------------------
package thermal_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        SHUTDOWN = 2'd2,
        COOLDOWN = 2'd3
    } thermal_state_t;

    function automatic int cnt_width(input int deb, input int cool);
        int longest;
        longest = (deb > cool) ? deb : cool;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/thermal_channel.sv
// ----------------------------------------------------------------------------
// thermal_channel
// One overheat protection channel: debounces the raw flag, asserts a
// registered shutdown after DEB_CYC consecutive high samples, holds it until
// COOL_CYC consecutive low samples (and, with LATCH_MODE=1, a clear), and
// keeps a sticky fault bit for software.
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset
//   overheated_i   : raw overheat flag, synchronous to clk_i
//   clear_i        : single-cycle software acknowledge
//   shut_off_o     : registered shutdown command
//   fault_sticky_o : registered, set on entry to SHUTDOWN
// ----------------------------------------------------------------------------
module thermal_channel
    import thermal_pkg::*;
#(
    parameter int DEB_CYC    = 4,
    parameter int COOL_CYC   = 16,
    parameter int LATCH_MODE = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic overheated_i,
    input  logic clear_i,
    output logic shut_off_o,
    output logic fault_sticky_o
);

    localparam int               CNT_W    = cnt_width(DEB_CYC, COOL_CYC);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_MAX = CNT_W'(COOL_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    thermal_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shut_q, shut_d;
    logic             sticky_q, sticky_d;

    logic             enter_shutdown;
    logic             release_by_clear;
    logic [CNT_W-1:0] cool_cnt;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        sticky_d         = sticky_q;
        enter_shutdown   = 1'b0;
        release_by_clear = 1'b0;
        cool_cnt         = CNT_ONE;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (overheated_i) begin
                    if (DEB_CYC == 1) begin
                        state_d        = SHUTDOWN;
                        enter_shutdown = 1'b1;
                    end else begin
                        state_d = DEBOUNCE;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            DEBOUNCE: begin
                if (!overheated_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d        = SHUTDOWN;
                    cnt_d          = '0;
                    enter_shutdown = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            SHUTDOWN, COOLDOWN: begin
                if (overheated_i) begin
                    state_d        = SHUTDOWN;
                    cnt_d          = '0;
                    enter_shutdown = 1'b1;
                end else begin
                    // Count of consecutive low samples after this edge; the
                    // first low sample out of SHUTDOWN counts as one, so
                    // COOL_CYC=1 completes straight from SHUTDOWN.
                    if (state_q == COOLDOWN)
                        cool_cnt = (cnt_q >= COOL_MAX) ? COOL_MAX : cnt_q + CNT_ONE;
                    if (cool_cnt == COOL_MAX) begin
                        if (LATCH_MODE == 0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (clear_i) begin
                            state_d          = IDLE;
                            cnt_d            = '0;
                            release_by_clear = 1'b1;
                        end else begin
                            // Cool-down done but latched: wait for software.
                            state_d = COOLDOWN;
                            cnt_d   = COOL_MAX;
                        end
                    end else begin
                        state_d = COOLDOWN;
                        cnt_d   = cool_cnt;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Clear only acknowledges a fault that is no longer active; a new
        // entry into SHUTDOWN on the same edge wins.
        if ((clear_i && (state_q == IDLE || state_q == DEBOUNCE)) || release_by_clear)
            sticky_d = 1'b0;
        if (enter_shutdown)
            sticky_d = 1'b1;
    end

    assign shut_d = (state_d == SHUTDOWN) || (state_d == COOLDOWN);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shut_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shut_q   <= shut_d;
            sticky_q <= sticky_d;
        end
    end

    assign shut_off_o     = shut_q;
    assign fault_sticky_o = sticky_q;

endmodule

// File: rtl/thermal_shutdown_ctrl.sv
// ----------------------------------------------------------------------------
// thermal_shutdown_ctrl
// Multi-channel overheat protection controller. One independent
// thermal_channel per sensor, plus an OR of all shutdown commands.
// Ports:
//   clk               : clock, rising edge
//   areset            : asynchronous active-high reset
//   cpu_overheated    : per-channel raw overheat flags
//   clear             : software acknowledge, shared by all channels
//   shut_off_computer : registered per-channel shutdown command
//   fault_sticky      : registered per-channel sticky fault flag
//   any_shutdown      : OR of shut_off_computer (register-driven only)
// ----------------------------------------------------------------------------
module thermal_shutdown_ctrl
    import thermal_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEB_CYC    = 4,
    parameter int COOL_CYC   = 16,
    parameter int LATCH_MODE = 0
) (
    input  logic            clk,
    input  logic            areset,
    input  logic [N_CH-1:0] cpu_overheated,
    input  logic            clear,
    output logic [N_CH-1:0] shut_off_computer,
    output logic [N_CH-1:0] fault_sticky,
    output logic            any_shutdown
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        thermal_channel #(
            .DEB_CYC    (DEB_CYC),
            .COOL_CYC   (COOL_CYC),
            .LATCH_MODE (LATCH_MODE)
        ) u_channel (
            .clk_i          (clk),
            .rst_i          (areset),
            .overheated_i   (cpu_overheated[ch]),
            .clear_i        (clear),
            .shut_off_o     (shut_off_computer[ch]),
            .fault_sticky_o (fault_sticky[ch])
        );
    end

    assign any_shutdown = |shut_off_computer;

endmodule

// File: tb/tb_thermal_shutdown_ctrl.sv
// ----------------------------------------------------------------------------
// tb_thermal_shutdown_ctrl
// Two instances: A with defaults (4 ch, DEB 4, COOL 16, auto release) and
// B latched (2 ch, DEB 1, COOL 2, LATCH_MODE 1). A run-length model of each
// channel is compared against the DUTs every cycle, alongside directed
// literal checks and a randomized phase.
// ----------------------------------------------------------------------------
module tb_thermal_shutdown_ctrl;

    localparam int A_N = 4, A_DEB = 4, A_COOL = 16, A_LM = 0;
    localparam int B_N = 2, B_DEB = 1, B_COOL = 2,  B_LM = 1;

    logic           clk = 1'b0;
    logic           areset;
    logic [A_N-1:0] oh_a;
    logic           clr_a;
    logic [A_N-1:0] shut_a, sticky_a;
    logic           any_a;
    logic [B_N-1:0] oh_b;
    logic           clr_b;
    logic [B_N-1:0] shut_b, sticky_b;
    logic           any_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    thermal_shutdown_ctrl #(
        .N_CH(A_N), .DEB_CYC(A_DEB), .COOL_CYC(A_COOL), .LATCH_MODE(A_LM)
    ) u_dut_a (
        .clk               (clk),
        .areset            (areset),
        .cpu_overheated    (oh_a),
        .clear             (clr_a),
        .shut_off_computer (shut_a),
        .fault_sticky      (sticky_a),
        .any_shutdown      (any_a)
    );

    thermal_shutdown_ctrl #(
        .N_CH(B_N), .DEB_CYC(B_DEB), .COOL_CYC(B_COOL), .LATCH_MODE(B_LM)
    ) u_dut_b (
        .clk               (clk),
        .areset            (areset),
        .cpu_overheated    (oh_b),
        .clear             (clr_b),
        .shut_off_computer (shut_b),
        .fault_sticky      (sticky_b),
        .any_shutdown      (any_b)
    );

    // Behavioural channel: tracks run lengths of high samples while healthy
    // and of low samples while faulted.
    typedef struct {
        bit fault;
        bit sticky;
        int hi_run;
        int lo_run;
    } ch_model_t;

    ch_model_t m_a[A_N];
    ch_model_t m_b[B_N];

    function automatic ch_model_t model_reset();
        ch_model_t r;
        r.fault  = 1'b0;
        r.sticky = 1'b0;
        r.hi_run = 0;
        r.lo_run = 0;
        return r;
    endfunction

    function automatic ch_model_t model_step(input ch_model_t m, input int deb,
                                             input int cool, input int lm,
                                             input bit oh, input bit clr);
        ch_model_t r = m;
        if (!r.fault) begin
            if (clr) r.sticky = 1'b0;
            if (oh) begin
                r.hi_run = r.hi_run + 1;
                if (r.hi_run >= deb) begin
                    r.fault  = 1'b1;
                    r.sticky = 1'b1;
                    r.hi_run = 0;
                    r.lo_run = 0;
                end
            end else begin
                r.hi_run = 0;
            end
        end else if (oh) begin
            r.lo_run = 0;
        end else begin
            r.lo_run = r.lo_run + 1;
            if (r.lo_run >= cool && (lm == 0 || clr)) begin
                r.fault  = 1'b0;
                r.hi_run = 0;
                if (lm != 0) r.sticky = 1'b0;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < A_N; i++) m_a[i] <= model_reset();
            for (int i = 0; i < B_N; i++) m_b[i] <= model_reset();
        end else begin
            for (int i = 0; i < A_N; i++)
                m_a[i] <= model_step(m_a[i], A_DEB, A_COOL, A_LM, oh_a[i], clr_a);
            for (int i = 0; i < B_N; i++)
                m_b[i] <= model_step(m_b[i], B_DEB, B_COOL, B_LM, oh_b[i], clr_b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin : compare
        logic [A_N-1:0] es_a, ek_a;
        logic [B_N-1:0] es_b, ek_b;
        for (int i = 0; i < A_N; i++) begin
            es_a[i] = m_a[i].fault;
            ek_a[i] = m_a[i].sticky;
        end
        for (int i = 0; i < B_N; i++) begin
            es_b[i] = m_b[i].fault;
            ek_b[i] = m_b[i].sticky;
        end
        check("model A shut",   32'(shut_a),   32'(es_a));
        check("model A sticky", 32'(sticky_a), 32'(ek_a));
        check("model A any",    32'(any_a),    32'(|es_a));
        check("model B shut",   32'(shut_b),   32'(es_b));
        check("model B sticky", 32'(sticky_b), 32'(ek_b));
        check("model B any",    32'(any_b),    32'(|es_b));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        oh_a   = '0;
        clr_a  = 1'b0;
        oh_b   = '0;
        clr_b  = 1'b0;

        // Reset state
        cyc(3);
        check("reset shut A",   32'(shut_a),   0);
        check("reset sticky A", 32'(sticky_a), 0);
        check("reset any A",    32'(any_a),    0);
        check("reset shut B",   32'(shut_b),   0);
        areset = 1'b0;
        cyc(1);
        check("post-reset shut A", 32'(shut_a), 0);

        // Sustained overheat on ch0: asserts after the 4th edge
        oh_a[0] = 1'b1;
        cyc(3);
        check("ch0 before 4th edge", 32'(shut_a[0]), 0);
        cyc(1);
        check("ch0 shut vector",   32'(shut_a),   32'h1);
        check("ch0 sticky vector", 32'(sticky_a), 32'h1);
        check("ch0 any",           32'(any_a),    1);
        check("model pins ch0",    32'(m_a[0].fault), 1);
        oh_a[0] = 1'b0;

        // Glitch train on ch1 never asserts
        oh_a[1] = 1'b1; cyc(3);
        oh_a[1] = 1'b0; cyc(1);
        oh_a[1] = 1'b1; cyc(3);
        oh_a[1] = 1'b0; cyc(1);
        check("ch1 glitch shut",   32'(shut_a[1]),   0);
        check("ch1 glitch sticky", 32'(sticky_a[1]), 0);

        // Cool-down restart on ch2
        oh_a[2] = 1'b1; cyc(4);
        check("ch2 shutdown", 32'(shut_a[2]), 1);
        oh_a[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("ch2 hold first cool", 32'(shut_a[2]), 1);
        end
        oh_a[2] = 1'b1; cyc(1);
        check("ch2 hold reheat", 32'(shut_a[2]), 1);
        oh_a[2] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            check("ch2 hold second cool", 32'(shut_a[2]), 1);
        end
        cyc(1);
        check("ch2 release at 16", 32'(shut_a[2]), 0);
        check("ch2 sticky kept",   32'(sticky_a[2]), 1);

        // Sticky behaviour in auto-release mode on ch3
        oh_a[3] = 1'b1; cyc(4);
        check("ch3 shutdown", 32'(shut_a[3]), 1);
        oh_a[3] = 1'b0; cyc(3);
        clr_a = 1'b1; cyc(1); clr_a = 1'b0;
        check("ch3 sticky survives clear in cooldown", 32'(sticky_a[3]), 1);
        check("ch3 still shut",                        32'(shut_a[3]),   1);
        check("ch0 sticky cleared in idle",            32'(sticky_a[0]), 0);
        cyc(20);
        check("ch3 released",     32'(shut_a[3]),   0);
        check("ch3 sticky after", 32'(sticky_a[3]), 1);
        clr_a = 1'b1; cyc(1); clr_a = 1'b0;
        check("ch3 sticky cleared in idle", 32'(sticky_a[3]), 0);
        oh_a[3] = 1'b1; cyc(3);
        clr_a = 1'b1; cyc(1); clr_a = 1'b0;
        check("ch3 set wins over clear", 32'(sticky_a[3]), 1);
        check("ch3 shut on entry",       32'(shut_a[3]),   1);
        oh_a[3] = 1'b0;

        // Latched instance: cool-down alone never releases
        oh_b[0] = 1'b1; cyc(1);
        check("B ch0 shut",   32'(shut_b[0]),   1);
        check("B ch0 sticky", 32'(sticky_b[0]), 1);
        oh_b[0] = 1'b0; cyc(20);
        check("B ch0 latched", 32'(shut_b[0]), 1);
        clr_b = 1'b1; cyc(1); clr_b = 1'b0;
        check("B ch0 release shut",   32'(shut_b[0]),   0);
        check("B ch0 release sticky", 32'(sticky_b[0]), 0);
        check("B any released",       32'(any_b),       0);

        // Asynchronous reset during shutdown
        oh_a = '1;
        oh_b = '1;
        cyc(4);
        check("all A shut",  32'(shut_a), 32'hf);
        check("all B shut",  32'(shut_b), 32'h3);
        #1 areset = 1'b1;
        #1;
        check("async reset shut A",   32'(shut_a),   0);
        check("async reset sticky A", 32'(sticky_a), 0);
        check("async reset any A",    32'(any_a),    0);
        check("async reset shut B",   32'(shut_b),   0);
        check("async reset sticky B", 32'(sticky_b), 0);
        @(posedge clk); #2;
        areset = 1'b0;
        cyc(3);
        check("post reset full debounce", 32'(shut_a), 0);
        cyc(1);
        check("post reset assert", 32'(shut_a), 32'hf);

        // Randomized phase: long low runs so cool-downs complete
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            for (int i = 0; i < A_N; i++)
                oh_a[i] = oh_a[i] ? ($urandom_range(3) != 0) : ($urandom_range(23) == 0);
            for (int i = 0; i < B_N; i++)
                oh_b[i] = oh_b[i] ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
            clr_a  = ($urandom_range(15) == 0);
            clr_b  = ($urandom_range(5) == 0);
            areset = ($urandom_range(599) == 0);
        end
        areset = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
